// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } regfile_state_e;

    localparam int MAX_WR = 2;

    // Later (higher-index) ports override earlier ones; result is {found, port}.
    function automatic logic [1:0] wr_match(input logic [MAX_WR-1:0] hit);
        logic [1:0] res;
        res = 2'b00;
        for (int p = 0; p < MAX_WR; p++) begin
            if (hit[p]) begin
                res = {1'b1, p[0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: sweeps INIT_VAL through every register after reset or clr_req.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          ready,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    regfile_state_e state_r;
    logic [AW-1:0]  ptr_r;
    logic           ready_r;

    // Sweep FSM; ready rises the cycle after the last register is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= INIT;
            ptr_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    if (clr_req) begin
                        ptr_r <= '0;
                    end else if (ptr_r == LAST_ADDR) begin
                        state_r <= RUN;
                        ptr_r   <= '0;
                        ready_r <= 1'b1;
                    end else begin
                        ptr_r <= ptr_r + AW'(1);
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state_r <= INIT;
                        ptr_r   <= '0;
                        ready_r <= 1'b0;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= INIT;
                    ptr_r   <= '0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = ready_r;
    assign sweep_we   = (state_r == INIT);
    assign sweep_addr = ptr_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with zero register, write bypass and clear sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              NRD      = 2,
    parameter int              NWR      = 1,
    parameter int              BYPASS   = 1,
    parameter int              ZERO_REG = 1,
    parameter logic [XLEN-1:0] INIT_VAL = {XLEN{1'b0}},
    localparam int             AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                ready,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data
);

    logic [XLEN-1:0] mem_r [NREGS];
    logic            ready_s;
    logic            sweep_we_s;
    logic [AW-1:0]   sweep_addr_s;
    logic [NWR-1:0]  we_s;
    logic [NWR-1:0]  commit_s;

    regfile_clr_seq #(.NREGS(NREGS)) u_clr_seq (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .ready      (ready_s),
        .sweep_we   (sweep_we_s),
        .sweep_addr (sweep_addr_s)
    );

    assign ready = ready_s;

    // Qualify user writes and keep only the winning port per address.
    always_comb begin
        logic [MAX_WR-1:0] hit_w;
        logic [1:0]        m_w;
        we_s     = '0;
        commit_s = '0;
        hit_w    = '0;
        m_w      = 2'b00;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && ready_s && !(ZERO_REG != 0 && wr_addr[p*AW +: AW] == '0)) begin
                we_s[p] = 1'b1;
            end else begin
                we_s[p] = 1'b0;
            end
        end
        for (int p = 0; p < NWR; p++) begin
            hit_w = '0;
            for (int q = 0; q < NWR; q++) begin
                hit_w[q] = we_s[q] && (wr_addr[q*AW +: AW] == wr_addr[p*AW +: AW]);
            end
            m_w = wr_match(hit_w);
            commit_s[p] = we_s[p] && (int'(m_w[0]) == p);
        end
    end

    // Storage array, no reset term; the sweep owns it while active.
    always_ff @(posedge clk) begin
        if (sweep_we_s) begin
            mem_r[sweep_addr_s] <= INIT_VAL;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (commit_s[p]) begin
                    mem_r[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Combinational read ports with zero register and optional forwarding.
    always_comb begin
        logic [MAX_WR-1:0] hit_r;
        logic [1:0]        m_r;
        logic [AW-1:0]     ra;
        rd_data = '0;
        hit_r   = '0;
        m_r     = 2'b00;
        ra      = '0;
        for (int r = 0; r < NRD; r++) begin
            ra    = rd_addr[r*AW +: AW];
            hit_r = '0;
            for (int q = 0; q < NWR; q++) begin
                hit_r[q] = we_s[q] && (wr_addr[q*AW +: AW] == ra);
            end
            m_r = wr_match(hit_r);
            if (!ready_s) begin
                rd_data[r*XLEN +: XLEN] = '0;
            end else if (ZERO_REG != 0 && ra == '0) begin
                rd_data[r*XLEN +: XLEN] = '0;
            end else if (BYPASS != 0 && m_r[1]) begin
                rd_data[r*XLEN +: XLEN] = wr_data[int'(m_r[0])*XLEN +: XLEN];
            end else begin
                rd_data[r*XLEN +: XLEN] = mem_r[ra];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, clear/reset sequences and random traffic vs a model.
module tb_regfile_mp;

    localparam int          NREGS  = 32;
    localparam logic [31:0] INIT_V = 32'h0C0F_FEE0;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic        ready;
    logic        nb_ready;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [31:0] nb_rd_data;

    regfile_mp #(.XLEN(32), .NREGS(NREGS), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1),
                 .INIT_VAL(INIT_V)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    regfile_mp #(.XLEN(32), .NREGS(NREGS), .NRD(1), .NWR(1), .BYPASS(0), .ZERO_REG(1),
                 .INIT_VAL(INIT_V)) dut_nb (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(nb_ready),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[4:0]), .wr_data(wr_data[31:0]),
        .rd_addr(rd_addr[4:0]), .rd_data(nb_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: architectural contents plus remaining sweep cycles.
    logic [31:0] mem_a [NREGS];
    logic [31:0] mem_b [NREGS];
    int          sweep_left;
    int          n_cmp;
    int          n_bad;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] enb;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit is_b);
        logic [31:0] v;
        if (sweep_left != 0 || a == 5'd0) return 32'h0;
        v = is_b ? mem_b[a] : mem_a[a];
        if (!is_b) begin
            if (wr_en[0] && wr_addr[4:0] == a) v = wr_data[31:0];
            if (wr_en[1] && wr_addr[9:5] == a) v = wr_data[63:32];
        end
        return v;
    endfunction

    task automatic model_edge();
        if (sweep_left == 0) begin
            if (wr_en[0] && wr_addr[4:0] != 5'd0) begin
                mem_a[wr_addr[4:0]] = wr_data[31:0];
                mem_b[wr_addr[4:0]] = wr_data[31:0];
            end
            if (wr_en[1] && wr_addr[9:5] != 5'd0) mem_a[wr_addr[9:5]] = wr_data[63:32];
            if (clr_req) sweep_left = NREGS;
        end else if (clr_req) begin
            sweep_left = NREGS;
        end else begin
            sweep_left--;
            if (sweep_left == 0) begin
                for (int i = 0; i < NREGS; i++) begin
                    mem_a[i] = INIT_V;
                    mem_b[i] = INIT_V;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic check_model();
        chk("rd0",      rd_data[31:0],  exp_rd(rd_addr[4:0], 1'b0));
        chk("rd1",      rd_data[63:32], exp_rd(rd_addr[9:5], 1'b0));
        chk("nb_rd",    nb_rd_data,     exp_rd(rd_addr[4:0], 1'b1));
        chk("ready",    {31'd0, ready},    {31'd0, sweep_left == 0});
        chk("nb_ready", {31'd0, nb_ready}, {31'd0, sweep_left == 0});
    endtask

    initial begin
        int cnt;
        n_cmp = 0;
        n_bad = 0;
        tbl[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  5'd5, 5'd6, 32'hDEADBEEF, INIT_V, INIT_V};
        tbl[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd5, 5'd6, 32'hDEADBEEF, INIT_V, 32'hDEADBEEF};
        tbl[2]  = '{2'b01, 5'd7, 32'h1234,     5'd0, 32'h0,  5'd7, 5'd0, 32'h1234, 32'h0, INIT_V};
        tbl[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd7, 5'd7, 32'h1234, 32'h1234, 32'h1234};
        tbl[4]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,  5'd0, 5'd7, 32'h0, 32'h1234, 32'h0};
        tbl[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[6]  = '{2'b11, 5'd3, 32'hA,        5'd3, 32'hB,  5'd3, 5'd3, 32'hB, 32'hB, INIT_V};
        tbl[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd3, 5'd2, 32'hB, INIT_V, 32'hA};
        tbl[8]  = '{2'b11, 5'd8, 32'h11,       5'd9, 32'h22, 5'd8, 5'd9, 32'h11, 32'h22, INIT_V};
        tbl[9]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd8, 32'h22, 32'h11, INIT_V};
        tbl[10] = '{2'b10, 5'd0, 32'h0,        5'd0, 32'h5,  5'd0, 5'd8, 32'h0, 32'h11, 32'h0};

        rst = 1'b0; clr_req = 1'b0; wr_en = 2'b00; wr_addr = '0; wr_data = '0;
        rd_addr = {5'd6, 5'd5};
        sweep_left = NREGS;
        tick();
        tick();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rd0", rd_data[31:0], 32'h0);
        chk("rst_rd1", rd_data[63:32], 32'h0);
        rst = 1'b1;

        cnt = 0;
        while (!ready && cnt < 100) begin
            check_model();
            tick();
            cnt++;
        end
        chk("init_sweep_len", 32'(cnt), 32'(NREGS));
        for (int a = 0; a < NREGS; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #3 check_model();
            tick();
        end

        foreach (tbl[i]) begin
            wr_en   = tbl[i].we;
            wr_addr = {tbl[i].wa1, tbl[i].wa0};
            wr_data = {tbl[i].wd1, tbl[i].wd0};
            rd_addr = {tbl[i].ra1, tbl[i].ra0};
            #3;
            chk($sformatf("vec%0d_rd0", i), rd_data[31:0],  tbl[i].e0);
            chk($sformatf("vec%0d_rd1", i), rd_data[63:32], tbl[i].e1);
            chk($sformatf("vec%0d_nb", i),  nb_rd_data,     tbl[i].enb);
            chk($sformatf("vec%0d_rdy", i), {31'd0, ready}, 32'd1);
            tick();
        end

        // Fill regs 1..31, clear, try writes mid-sweep, then reset at sweep cycle 10.
        for (int a = 1; a < NREGS; a++) begin
            wr_en = 2'b01; wr_addr = {5'd0, 5'(a)}; wr_data = {32'h0, 32'(a)};
            rd_addr = {5'(a), 5'(a - 1)};
            #3 check_model();
            tick();
        end
        wr_en = 2'b00; clr_req = 1'b1; rd_addr = {5'd31, 5'd17};
        #3 check_model();
        tick();
        clr_req = 1'b0;
        #3 chk("clr_ready_low", {31'd0, ready}, 32'd0);
        for (int s = 0; s < 9; s++) begin
            wr_en = 2'b11;
            wr_addr = {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))};
            wr_data = {$urandom, $urandom};
            check_model();
            tick();
            #3;
        end
        tick();
        rst = 1'b0;
        sweep_left = NREGS;
        #2;
        chk("midsweep_rst_ready", {31'd0, ready}, 32'd0);
        chk("midsweep_rst_rd", rd_data[31:0], 32'h0);
        tick();
        rst = 1'b1;
        cnt = 0;
        while (!ready && cnt < 100) begin
            check_model();
            tick();
            cnt++;
        end
        chk("restart_sweep_len", 32'(cnt), 32'(NREGS));
        wr_en = 2'b00;
        for (int a = 0; a < NREGS; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #3;
            chk("post_clr_rd0", rd_data[31:0],  (a == 0) ? 32'h0 : INIT_V);
            chk("post_clr_rd1", rd_data[63:32], INIT_V);
            tick();
        end

        for (int n = 0; n < 1500; n++) begin
            logic [4:0] wa0, wa1;
            wa0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wa1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wr_en   = 2'($urandom_range(0, 3));
            wr_addr = {wa1, wa0};
            wr_data = {$urandom, $urandom};
            clr_req = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 2))
                0:       rd_addr = {wa1, wa0};
                1:       rd_addr = {wa0, wa1};
                default: rd_addr = {5'($urandom), 5'($urandom)};
            endcase
            #3 check_model();
            tick();
        end
        clr_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
